// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the rv32 memory arbiter.
//   arb_state_t      arbiter FSM states (idle, fetch granted, load/store granted)
//   ARB_MODE_*       arbitration policy selectors
//   GRANT_*          2-bit owner encodings driven on grant_o
package rv32_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_INSTR = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

endpackage

// File: rtl/rv32_mod_arb_timeout.sv
// rv32_mod_arb_timeout: per-transaction watchdog for the memory arbiter.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      hold the count at zero (asserted while no grant is active)
//   en_i         count one waiting cycle (granted, no response yet)
//   expired_o    high in the waiting cycle in which the budget runs out
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module rv32_mod_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TO_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear_i, en_i};
            assign expired_o = 1'b0;
        end else begin : g_on
            logic [TO_W-1:0] cnt_q, cnt_d;
            always_comb cnt_d = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
            // The count starts at 0 in the first granted cycle, so the error
            // lands in the TIMEOUT_CYCLES-th cycle that mem_req is high.
            assign expired_o = en_i && cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
        end
    endgenerate

endmodule

// File: rtl/rv32_mod_mem_arbiter.sv
// rv32_mod_mem_arbiter: shares one memory handshake port between the fetch
// port and the load/store port of the rv32 core.
//   clk, rst_n                         clock, asynchronous active-low reset
//   instr_req_i/addr_i                 fetch request (held until ack/err)
//   instr_ack_o/err_o/data_o           fetch completion pulse, error pulse, read word
//   data_req_i/wr_i/be_i/addr_i/data_i load/store request (held until ack/err)
//   data_ack_o/err_o/data_o            load/store completion, error, read word
//   mem_req_o/wr_o/be_o/addr_o/data_o  shared port request side
//   mem_ack_i/err_i/data_i             shared port response side
//   grant_o                            registered owner: 00 none, 01 instr, 10 data
import rv32_pkg::*;

module rv32_mod_mem_arbiter #(
    parameter int ARB_MODE       = ARB_MODE_FIXED,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_ack_o,
    output logic        instr_err_o,
    output logic [31:0] instr_data_o,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_data_i,
    output logic        data_ack_o,
    output logic        data_err_o,
    output logic [31:0] data_data_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_data_i,
    output logic [1:0]  grant_o
);

    arb_state_t state_q, state_d;
    logic       rr_data_q, rr_data_d;
    logic       gnt_i, gnt_d, ok, bad, expired;

    rv32_mod_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == ARB_IDLE),
        .en_i     (mem_req_o && !mem_ack_i && !mem_err_i),
        .expired_o(expired)
    );

    // rr_data_q remembers whether the last grant went to the data port; in
    // round-robin mode a tie goes to whichever port was not served last.
    always_comb begin
        state_d   = state_q;
        rr_data_d = rr_data_q;
        if (state_q == ARB_IDLE) begin
            if (instr_req_i && data_req_i)
                state_d = (ARB_MODE == ARB_MODE_RR && rr_data_q) ? ARB_GNT_I : ARB_GNT_D;
            else if (data_req_i)
                state_d = ARB_GNT_D;
            else if (instr_req_i)
                state_d = ARB_GNT_I;
            if (state_d != ARB_IDLE)
                rr_data_d = state_d == ARB_GNT_D;
        end else if (mem_ack_i || mem_err_i || expired) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            rr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_data_q <= rr_data_d;
        end
    end

    assign gnt_i = state_q == ARB_GNT_I;
    assign gnt_d = state_q == ARB_GNT_D;

    assign mem_req_o  = gnt_i || gnt_d;
    assign mem_wr_o   = gnt_d && data_wr_i;
    assign mem_be_o   = gnt_d ? data_be_i : gnt_i ? 4'hF : 4'h0;
    assign mem_addr_o = gnt_d ? data_addr_i : gnt_i ? instr_addr_i : '0;
    assign mem_data_o = gnt_d ? data_data_i : '0;

    // Error wins over a simultaneous ack; a requester that dropped its req
    // (abort) sees neither, while the bus still waits for the memory.
    assign ok  = mem_ack_i && !mem_err_i;
    assign bad = mem_err_i || expired;

    assign instr_ack_o  = gnt_i && instr_req_i && ok;
    assign instr_err_o  = gnt_i && instr_req_i && bad;
    assign data_ack_o   = gnt_d && data_req_i && ok;
    assign data_err_o   = gnt_d && data_req_i && bad;
    assign instr_data_o = instr_ack_o ? mem_data_i : '0;
    assign data_data_o  = data_ack_o ? mem_data_i : '0;

    assign grant_o = gnt_i ? GRANT_INSTR : gnt_d ? GRANT_DATA : GRANT_NONE;

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// tb_rv32_mod_mem_arbiter: directed bench for the memory arbiter. Two
// instances share the requester/memory stimulus: u_fix (fixed priority,
// 4-cycle timeout) and u_rr (round-robin, 4-cycle timeout).
module tb_rv32_mod_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, data_req, data_wr, mem_ack, mem_err;
    logic [3:0]  data_be;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;

    logic        f_iack, f_ierr, f_dack, f_derr, f_mreq, f_mwr;
    logic [31:0] f_idata, f_ddata, f_maddr, f_mdata;
    logic [3:0]  f_mbe;
    logic [1:0]  f_gnt;

    logic        r_iack, r_ierr, r_dack, r_derr, r_mreq, r_mwr;
    logic [31:0] r_idata, r_ddata, r_maddr, r_mdata;
    logic [3:0]  r_mbe;
    logic [1:0]  r_gnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32_mod_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(4)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_ack_o(f_iack), .instr_err_o(f_ierr), .instr_data_o(f_idata),
        .data_req_i(data_req), .data_wr_i(data_wr), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_data_i(data_wdata),
        .data_ack_o(f_dack), .data_err_o(f_derr), .data_data_o(f_ddata),
        .mem_req_o(f_mreq), .mem_wr_o(f_mwr), .mem_be_o(f_mbe),
        .mem_addr_o(f_maddr), .mem_data_o(f_mdata),
        .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_data_i(mem_rdata),
        .grant_o(f_gnt)
    );

    rv32_mod_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_ack_o(r_iack), .instr_err_o(r_ierr), .instr_data_o(r_idata),
        .data_req_i(data_req), .data_wr_i(data_wr), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_data_i(data_wdata),
        .data_ack_o(r_dack), .data_err_o(r_derr), .data_data_o(r_ddata),
        .mem_req_o(r_mreq), .mem_wr_o(r_mwr), .mem_be_o(r_mbe),
        .mem_addr_o(r_maddr), .mem_data_o(r_mdata),
        .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_data_i(mem_rdata),
        .grant_o(r_gnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    logic [1:0] rr_order [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        rst_n = 1'b0;
        {instr_req, data_req, data_wr, mem_ack, mem_err} = '0;
        data_be = '0; instr_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;

        // Reset state
        step(); #1;
        check("rst_grant", f_gnt, 2'b00);
        check("rst_mem_req", f_mreq, 0);
        check("rst_acks", {f_iack, f_ierr, f_dack, f_derr}, 4'b0);
        rst_n = 1'b1;

        // 1: single fetch
        step(); instr_req = 1; instr_addr = 32'h100; #1;
        check("t1_idle_grant", f_gnt, 2'b00);
        check("t1_idle_req", f_mreq, 0);
        step(); mem_ack = 1; mem_rdata = 32'h13; #1;
        check("t1_mem_req", f_mreq, 1);
        check("t1_mem_addr", f_maddr, 32'h100);
        check("t1_mem_be", f_mbe, 4'hF);
        check("t1_mem_wr", f_mwr, 0);
        check("t1_grant", f_gnt, 2'b01);
        check("t1_iack", f_iack, 1);
        check("t1_idata", f_idata, 32'h13);
        check("t1_dack", f_dack, 0);
        step(); instr_req = 0; mem_ack = 0; #1;
        check("t1_grant_after", f_gnt, 2'b00);
        check("t1_iack_after", f_iack, 0);

        // 2: tie under fixed priority, data wins, one idle cycle, then fetch
        step();
        instr_req = 1; instr_addr = 32'h104;
        data_req = 1; data_wr = 1; data_be = 4'b0011; data_addr = 32'h2000; data_wdata = 32'hDEADBEEF;
        step(); #1;
        check("t2_grant_d", f_gnt, 2'b10);
        check("t2_mem_wr", f_mwr, 1);
        check("t2_mem_be", f_mbe, 4'h3);
        check("t2_mem_addr", f_maddr, 32'h2000);
        check("t2_mem_data", f_mdata, 32'hDEADBEEF);
        mem_ack = 1; #1;
        check("t2_dack", f_dack, 1);
        check("t2_iack_non_owner", f_iack, 0);
        step(); data_req = 0; data_wr = 0; mem_ack = 0; #1;
        check("t2_turnaround_grant", f_gnt, 2'b00);
        check("t2_turnaround_req", f_mreq, 0);
        step(); #1;
        check("t2_grant_i", f_gnt, 2'b01);
        check("t2_i_addr", f_maddr, 32'h104);
        check("t2_i_be", f_mbe, 4'hF);
        check("t2_i_wr", f_mwr, 0);
        check("t2_i_wdata", f_mdata, 0);
        mem_ack = 1; mem_rdata = 32'h00500093; #1;
        check("t2_iack", f_iack, 1);
        check("t2_idata", f_idata, 32'h00500093);
        step(); instr_req = 0; mem_ack = 0;

        // 3: round-robin with both ports requesting continuously
        step(); instr_req = 1; instr_addr = 32'h200; data_req = 1; data_addr = 32'h3000; data_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_idle%0d", k), r_gnt, 2'b00);
            step(); mem_ack = 1; mem_rdata = 32'h1000 + k; #1;
            check($sformatf("t3_grant%0d", k), r_gnt, rr_order[k]);
            check($sformatf("t3_dack%0d", k), r_dack, rr_order[k] == 2'b10);
            check($sformatf("t3_iack%0d", k), r_iack, rr_order[k] == 2'b01);
            step(); mem_ack = 0;
        end
        instr_req = 0; data_req = 0;

        // 4: timeout after four granted cycles, stray ack ignored afterwards
        step(); data_req = 1; data_wr = 0; data_addr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check($sformatf("t4_mem_req%0d", i), f_mreq, 1);
            check($sformatf("t4_derr%0d", i), f_derr, i == 3);
        end
        step(); data_req = 0; mem_ack = 1; #1;
        check("t4_req_dropped", f_mreq, 0);
        check("t4_idle", f_gnt, 2'b00);
        check("t4_stray_dack", f_dack, 0);
        check("t4_stray_iack", f_iack, 0);
        step(); mem_ack = 0;

        // 5a: ack and err together -> err only
        step(); instr_req = 1; instr_addr = 32'h108;
        step(); mem_ack = 1; mem_err = 1; #1;
        check("t5_ierr", f_ierr, 1);
        check("t5_iack", f_iack, 0);
        check("t5_derr_non_owner", f_derr, 0);
        step(); instr_req = 0; mem_ack = 0; mem_err = 0;

        // 5b: owner aborts, bus holds until mem_ack, no requester ack
        step(); data_req = 1; data_addr = 32'h4000;
        step(); data_req = 0; #1;
        check("t5_abort_req", f_mreq, 1);
        check("t5_abort_grant", f_gnt, 2'b10);
        step(); mem_ack = 1; #1;
        check("t5_abort_hold", f_mreq, 1);
        check("t5_abort_dack", f_dack, 0);
        step(); mem_ack = 0; #1;
        check("t5_abort_idle", f_gnt, 2'b00);

        // 6: async reset in GNT_D; round-robin pointer then says data-last,
        // so only a reset pointer gives the next tie to data
        step(); data_req = 1; data_addr = 32'h5000;
        step(); mem_ack = 1; #1;
        check("t6_pre_grant", r_gnt, 2'b10);
        check("t6_pre_dack", r_dack, 1);
        #1 rst_n = 0; #1;
        check("t6_rst_mem_req", r_mreq, 0);
        check("t6_rst_grant", r_gnt, 2'b00);
        check("t6_rst_dack", r_dack, 0);
        check("t6_rst_fix_dack", f_dack, 0);
        step(); rst_n = 1; mem_ack = 0; instr_req = 1; data_req = 1; #1;
        check("t6_idle", r_gnt, 2'b00);
        step(); #1;
        check("t6_first_tie", r_gnt, 2'b10);
        check("t6_first_tie_req", r_mreq, 1);
        step(); instr_req = 0; data_req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_mod_mem_arbiter.md
Name: rv32_mod_mem_arbiter

Overview:
Shares one external memory handshake port between the core's instruction-fetch port and its load/store port. Lets the single-cycle rv32imc core run on a single-ported memory or bus.
- Accepts the two requester buses unchanged (req/ack/err, held-request semantics).
- Grants one requester at a time and routes ack/err/read data back to it.
- Enforces a per-transaction timeout.

Parameters:
ARB_MODE, 0, 0 = fixed priority (data port wins ties), 1 = round-robin (alternate on ties).
TIMEOUT_CYCLES, 256, cycles from mem_req assertion to forced error; 0 disables the timeout.
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
instr_req  input  1  fetch request, held until ack/err
instr_addr  input  32  fetch address
instr_ack  output  1  fetch complete (1-cycle pulse)
instr_err  output  1  fetch failed (1-cycle pulse)
instr_data_o  output  32  fetched word, valid with instr_ack
data_req  input  1  LSU request, held until ack/err
data_wr  input  1  1 = write
data_be  input  4  byte enables
data_addr  input  32  LSU address
data_data_i  input  32  write data
data_ack  output  1  LSU complete
data_err  output  1  LSU failed
data_data_o  output  32  read data, valid with data_ack
mem_req  output  1  shared-port request
mem_wr  output  1  shared-port write
mem_be  output  4  shared-port byte enables
mem_addr  output  32  shared-port address
mem_data_o  output  32  shared-port write data
mem_ack  input  1  shared-port completion
mem_err  input  1  shared-port error
mem_data_i  input  32  shared-port read data
grant  output  2  current owner: 00 none, 01 instr, 10 data

Behaviour:
Reset:
- reset low asynchronously forces IDLE.
- Round-robin pointer resets to "instr last", so data wins the first tie.
- Timeout counter resets to 0.
- All outputs are 0 while reset is low and in IDLE.

States:
- IDLE: decision is combinational on sampled requests.
  - Only instr_req → GNT_I. Only data_req → GNT_D. Neither → stay IDLE.
  - Both, ARB_MODE=0 → GNT_D.
  - Both, ARB_MODE=1 → grant the port not granted last.
- GNT_I / GNT_D:
  - mem_req=1.
  - mem_addr, mem_wr, mem_be and mem_data_o come combinationally from the granted requester's live inputs. Requesters must hold these stable while req is high.
  - For GNT_I: mem_wr=0, mem_be=4'hF, mem_data_o=0.
  - On mem_ack or mem_err: pulse the matching ack/err to the owner in the same cycle, with read data passed through. Next state is IDLE.
  - mem_err has precedence if mem_ack and mem_err are both asserted: err only.

Latency and turnaround:
- Request seen at cycle N in IDLE gives mem_req at N+1.
- Earliest requester ack is at N+1.
- After completion there is exactly one IDLE cycle before the next grant (bus turnaround). This also guarantees the requester has dropped a stale req.

Round-robin pointer:
- Updates on entry into a grant state.
- A requester never waits more than one foreign transaction when ARB_MODE=1.

Timeout:
- Counter clears on grant entry and increments each granted cycle without mem_ack or mem_err.
- When it reaches TIMEOUT_CYCLES-1 without a response:
  - pulse err to the owner;
  - drop mem_req;
  - go to IDLE.
- A late mem_ack arriving in IDLE is ignored.

Abort: if the owner's req falls before completion:
- mem_req stays asserted until mem_ack, mem_err or timeout.
- The ack/err to the requester is suppressed.
- Next state is IDLE.

Ack/err to the non-owner is always 0. grant reflects the registered state.

Decomposition:
- Shared package rv32_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GNT_I, ARB_GNT_D};
  - ARB_MODE_FIXED=0 and ARB_MODE_RR=1 constants;
  - GRANT_* 2-bit encodings.
- Sub-module rv32_mod_arb_timeout:
  - inputs: clear, count-enable;
  - output: expired pulse;
  - parameter TIMEOUT_CYCLES; 0 → expired tied 0.

Test Plan:
1. Single fetch: instr_req=1, addr=0x100; mem_ack at cycle 1 with mem_data_i=0x00000013. Required: mem_req at cycle 1, mem_addr=0x100, mem_be=F, instr_ack=1 with instr_data_o=0x13 in that cycle, grant=01 then 00.
2. Tie, ARB_MODE=0: both req in the same cycle, data_addr=0x2000, data_wr=1, be=0011. Required:
   - data granted first (mem_wr=1, mem_be=3);
   - after data_ack, one IDLE cycle, then the instr grant.
3. Tie, ARB_MODE=1: both requesters re-request continuously for 4 transactions. Required: grant order D,I,D,I with no starvation.
4. Timeout: TIMEOUT_CYCLES=4, data_req, no mem_ack. Required:
   - data_err pulses 4 cycles after mem_req rises and mem_req drops;
   - a later stray mem_ack in IDLE produces no requester ack.
5. Error and abort:
   - mem_ack and mem_err together → only err to the owner.
   - Owner drops req mid-grant → mem_req held until mem_ack, with no requester ack.
6. Async reset mid-GNT_D: reset low between clock edges. Required: mem_req, grant and all acks go 0 immediately; after release the first tie goes to data.
